// File: rtl/store_rmw_ctrl_pkg.sv
// Shared types for the store read-modify-write controller: FSM state encoding
// and the line-width derivation used for port and register sizing.
package store_rmw_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WAIT  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  function automatic int line_width(input int word_width, input int word_count);
    return word_width * word_count;
  endfunction

endpackage

// File: rtl/store_rmw_ctrl_data_former.sv
// DataFormer merge stage: overlays the enabled bytes of one store word onto a
// full line; every byte outside the selected word passes through untouched.
module store_rmw_ctrl_data_former
  import store_rmw_ctrl_pkg::*;
#(
  parameter int WORD_WIDTH   = 32,
  parameter int WORD_COUNT   = 4,
  parameter int OFFSET_WIDTH = 4
) (
  input  logic [line_width(WORD_WIDTH, WORD_COUNT)-1:0] str,
  input  logic [WORD_WIDTH-1:0]                         wdata,
  input  logic [WORD_COUNT-1:0]                         bval,
  input  logic [OFFSET_WIDTH-1:0]                       offset,
  output logic [line_width(WORD_WIDTH, WORD_COUNT)-1:0] line_out
);

  localparam int SEL_W = OFFSET_WIDTH - 2;
  localparam int BYTES = WORD_WIDTH / 8;

  logic [SEL_W-1:0] word_sel;
  logic             unused_offset_bits;

  // Byte-within-word bits do not affect the merge; the word is always aligned.
  assign word_sel           = offset[OFFSET_WIDTH-1:2];
  assign unused_offset_bits = ^offset[1:0];

  genvar gi, gb;
  generate
    for (gi = 0; gi < WORD_COUNT; gi++) begin : g_word
      for (gb = 0; gb < BYTES; gb++) begin : g_byte
        localparam int LO = gi * WORD_WIDTH + gb * 8;
        assign line_out[LO +: 8] = ((word_sel == SEL_W'(gi)) && bval[gb])
                                   ? wdata[gb*8 +: 8] : str[LO +: 8];
      end
    end
  endgenerate

endmodule

// File: rtl/store_rmw_ctrl.sv
// Read-modify-write controller for partial-word stores into a line-wide RAM,
// with a one-entry hold register that short-circuits back-to-back same-line stores.
module store_rmw_ctrl
  import store_rmw_ctrl_pkg::*;
#(
  parameter int WORD_WIDTH   = 32,
  parameter int WORD_COUNT   = 4,
  parameter int OFFSET_WIDTH = 4,
  parameter int INDEX_WIDTH  = 6
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          req_valid,
  output logic                                          req_ready,
  input  logic [INDEX_WIDTH-1:0]                        req_index,
  input  logic [OFFSET_WIDTH-1:0]                       req_offset,
  input  logic [WORD_WIDTH-1:0]                         req_wdata,
  input  logic [WORD_COUNT-1:0]                         req_bval,
  input  logic                                          inv,
  output logic                                          ram_rd_en,
  output logic [INDEX_WIDTH-1:0]                        ram_rd_index,
  input  logic [line_width(WORD_WIDTH, WORD_COUNT)-1:0] ram_rd_data,
  output logic                                          ram_wr_en,
  output logic [INDEX_WIDTH-1:0]                        ram_wr_index,
  output logic [line_width(WORD_WIDTH, WORD_COUNT)-1:0] ram_wr_data,
  output logic                                          done
);

  localparam int LINE_W = line_width(WORD_WIDTH, WORD_COUNT);

  state_t                  state_reg, state_next;
  logic [INDEX_WIDTH-1:0]  index_reg;
  logic [OFFSET_WIDTH-1:0] offset_reg;
  logic [WORD_WIDTH-1:0]   wdata_reg;
  logic [WORD_COUNT-1:0]   bval_reg;
  logic [LINE_W-1:0]       base_line_reg;
  logic [LINE_W-1:0]       hold_line_reg;
  logic [INDEX_WIDTH-1:0]  hold_index_reg;
  logic                    hold_valid_reg;
  logic                    zero_done_reg;
  logic [LINE_W-1:0]       merged_line;
  logic                    accept;
  logic                    hold_hit;
  logic                    zero_bval;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    accept     = req_valid && (state_reg == S_IDLE);
    zero_bval  = (req_bval == '0);
    // A concurrent invalidate may mean the held copy is already stale.
    hold_hit   = hold_valid_reg && (req_index == hold_index_reg) && !inv;
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (accept && !zero_bval) state_next = hold_hit ? S_WRITE : S_READ;
      S_READ:  state_next = S_WAIT;
      S_WAIT:  state_next = S_WRITE;
      S_WRITE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      index_reg      <= '0;
      offset_reg     <= '0;
      wdata_reg      <= '0;
      bval_reg       <= '0;
      base_line_reg  <= '0;
      hold_line_reg  <= '0;
      hold_index_reg <= '0;
      hold_valid_reg <= 1'b0;
      zero_done_reg  <= 1'b0;
    end else begin
      zero_done_reg <= accept && zero_bval;
      if (accept) begin
        index_reg  <= req_index;
        offset_reg <= req_offset;
        wdata_reg  <= req_wdata;
        bval_reg   <= req_bval;
        if (hold_hit) base_line_reg <= hold_line_reg;
      end
      if (state_reg == S_WAIT) base_line_reg <= ram_rd_data;
      if (state_reg == S_WRITE) begin
        hold_line_reg  <= merged_line;
        hold_index_reg <= index_reg;
      end
      // Invalidate takes priority over the refill from a write in the same cycle.
      if (inv)                          hold_valid_reg <= 1'b0;
      else if (state_reg == S_WRITE)    hold_valid_reg <= 1'b1;
    end
  end

  store_rmw_ctrl_data_former #(
    .WORD_WIDTH  (WORD_WIDTH),
    .WORD_COUNT  (WORD_COUNT),
    .OFFSET_WIDTH(OFFSET_WIDTH)
  ) u_data_former (
    .str     (base_line_reg),
    .wdata   (wdata_reg),
    .bval    (bval_reg),
    .offset  (offset_reg),
    .line_out(merged_line)
  );

  assign req_ready    = (state_reg == S_IDLE);
  assign ram_rd_en    = (state_reg == S_READ);
  assign ram_rd_index = index_reg;
  assign ram_wr_en    = (state_reg == S_WRITE);
  assign ram_wr_index = index_reg;
  assign ram_wr_data  = merged_line;
  assign done         = (state_reg == S_WRITE) || zero_done_reg;

endmodule

// File: tb/tb_store_rmw_ctrl.sv
// Directed bench for store_rmw_ctrl: a table of store requests with hand-computed
// RAM-write lines and latencies, plus a reset-during-WAIT sequence.
module tb_store_rmw_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [5:0]   req_index;
  logic [3:0]   req_offset;
  logic [31:0]  req_wdata;
  logic [3:0]   req_bval;
  logic         inv;
  logic         ram_rd_en;
  logic [5:0]   ram_rd_index;
  logic [127:0] ram_rd_data;
  logic         ram_wr_en;
  logic [5:0]   ram_wr_index;
  logic [127:0] ram_wr_data;
  logic         done;

  logic [127:0] mem [0:63];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  store_rmw_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_index   (req_index),
    .req_offset  (req_offset),
    .req_wdata   (req_wdata),
    .req_bval    (req_bval),
    .inv         (inv),
    .ram_rd_en   (ram_rd_en),
    .ram_rd_index(ram_rd_index),
    .ram_rd_data (ram_rd_data),
    .ram_wr_en   (ram_wr_en),
    .ram_wr_index(ram_wr_index),
    .ram_wr_data (ram_wr_data),
    .done        (done)
  );

  // Line RAM with one-cycle registered read.
  always @(posedge clk) begin
    if (ram_rd_en) ram_rd_data <= mem[ram_rd_index];
    if (ram_wr_en) mem[ram_wr_index] <= ram_wr_data;
  end

  typedef struct {
    logic [5:0]   idx;
    logic [3:0]   off;
    logic [31:0]  wdata;
    logic [3:0]   bval;
    logic         inv;
    int           exp_lat;
    int           exp_rd;
    int           exp_wr;
    logic [127:0] exp_line;
  } vec_t;

  vec_t vecs [0:8];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int n, input vec_t v);
    int rd_cnt, wr_cnt, done_cnt, done_cyc;
    logic [127:0] wr_line;
    logic [5:0]   wr_idx;
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0; done_cyc = -1;
    wr_line = '0; wr_idx = '0;
    check($sformatf("v%0d ready", n), 128'(req_ready), 128'(1'b1));
    req_valid  = 1'b1;
    req_index  = v.idx;
    req_offset = v.off;
    req_wdata  = v.wdata;
    req_bval   = v.bval;
    inv        = v.inv;
    @(posedge clk); #1;
    // Scramble inputs after acceptance; the controller must use its captured copy.
    req_valid  = 1'b0;
    inv        = 1'b0;
    req_index  = 6'(~v.idx);
    req_offset = ~v.off;
    req_wdata  = ~v.wdata;
    req_bval   = ~v.bval;
    for (int c = 1; c <= 6; c++) begin
      if (ram_rd_en) rd_cnt++;
      if (ram_wr_en) begin
        wr_cnt++;
        wr_line = ram_wr_data;
        wr_idx  = ram_wr_index;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (ram_rd_en && ram_wr_en) check($sformatf("v%0d rd_wr_excl", n), 128'(1'b1), 128'(1'b0));
      @(posedge clk); #1;
    end
    check($sformatf("v%0d latency", n), 128'(done_cyc), 128'(v.exp_lat));
    check($sformatf("v%0d done_cnt", n), 128'(done_cnt), 128'(1));
    check($sformatf("v%0d rd_cnt", n), 128'(rd_cnt), 128'(v.exp_rd));
    check($sformatf("v%0d wr_cnt", n), 128'(wr_cnt), 128'(v.exp_wr));
    if (v.exp_wr != 0) begin
      check($sformatf("v%0d wr_data", n), wr_line, v.exp_line);
      check($sformatf("v%0d wr_index", n), 128'(wr_idx), 128'(v.idx));
    end
    $display("txn %0d idx=%0d off=%h wdata=%h bval=%b inv=%b lat=%0d rd=%0d wr=%0d line=%h",
             n, v.idx, v.off, v.wdata, v.bval, v.inv, done_cyc, rd_cnt, wr_cnt, wr_line);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[9] = 128'h00000000_00000000_00000000_FFFFFFFF;
    ram_rd_data = '0;
    rst = 1'b1; req_valid = 1'b0; inv = 1'b0;
    req_index = '0; req_offset = '0; req_wdata = '0; req_bval = '0;

    //           idx  off   wdata          bval     inv  lat rd wr  line
    vecs[0] = '{6'd5, 4'h8, 32'hAABBCCDD, 4'b1111, 1'b0, 3, 1, 1, 128'h00000000_AABBCCDD_00000000_00000000};
    vecs[1] = '{6'd5, 4'h0, 32'h00000001, 4'b1111, 1'b0, 1, 0, 1, 128'h00000000_AABBCCDD_00000000_00000001};
    vecs[2] = '{6'd9, 4'h1, 32'h11223344, 4'b0101, 1'b0, 3, 1, 1, 128'h00000000_00000000_00000000_FF22FF44};
    vecs[3] = '{6'd9, 4'hC, 32'h55667788, 4'b1000, 1'b0, 1, 0, 1, 128'h55000000_00000000_00000000_FF22FF44};
    vecs[4] = '{6'd9, 4'h4, 32'h99999999, 4'b0000, 1'b0, 1, 0, 0, 128'h0};
    vecs[5] = '{6'd9, 4'h6, 32'hCAFEBABE, 4'b0011, 1'b0, 1, 0, 1, 128'h55000000_00000000_0000BABE_FF22FF44};
    vecs[6] = '{6'd9, 4'h8, 32'h12345678, 4'b0010, 1'b1, 3, 1, 1, 128'h55000000_00005600_0000BABE_FF22FF44};
    vecs[7] = '{6'd9, 4'h0, 32'h00000000, 4'b1111, 1'b0, 1, 0, 1, 128'h55000000_00005600_0000BABE_00000000};
    vecs[8] = '{6'd3, 4'h4, 32'hDEADBEEF, 4'b1111, 1'b0, 3, 1, 1, 128'h00000000_00000000_DEADBEEF_00000000};

    repeat (2) @(posedge clk);
    #1;
    check("rst rd_en", 128'(ram_rd_en), 128'(1'b0));
    check("rst wr_en", 128'(ram_wr_en), 128'(1'b0));
    check("rst done", 128'(done), 128'(1'b0));
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst ready", 128'(req_ready), 128'(1'b1));

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Reset while the read data is in flight: no write, no done, hold cleared.
    req_valid = 1'b1; req_index = 6'd7; req_offset = 4'h0;
    req_wdata = 32'h99; req_bval = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rstw read", 128'(ram_rd_en), 128'(1'b1));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstw ready", 128'(req_ready), 128'(1'b1));
    for (int c = 0; c < 3; c++) begin
      check("rstw no_wr", 128'(ram_wr_en), 128'(1'b0));
      check("rstw no_done", 128'(done), 128'(1'b0));
      @(posedge clk); #1;
    end
    $display("txn rst-in-wait idx=7 dropped");
    check("rstw mem7", mem[7], 128'h0);

    // Line 3 was the hold entry before reset; it must now take the miss path.
    run_vec(9, '{6'd3, 4'h0, 32'h00000001, 4'b0001, 1'b0, 3, 1, 1,
                 128'h00000000_00000000_DEADBEEF_00000001});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
